// File: rtl/alarm_led_sequencer.sv
// Shares the alarm LED between the breathing alarm pattern and the countdown-timer blink,
// with snooze, alarm auto-timeout and a sticky missed-alarm flag.
module alarm_led_sequencer #(
  parameter int TICK_CYCLES   = 50_000_000,
  parameter int ALARM_TIMEOUT = 60,
  parameter int SNOOZE_TICKS  = 300,
  parameter int BLINK_TICKS   = 10,
  parameter int MAX_SNOOZE    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alarm_trig,
  input  logic       timer_done,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  input  logic       breath_pwm,
  output logic       breath_en,
  output logic       breath_rst_n,
  output logic       led_out,
  output logic       missed,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ALARM  = 2'b01,
    S_SNOOZE = 2'b10,
    S_BLINK  = 2'b11
  } state_t;

  localparam int CW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int TMAX = (ALARM_TIMEOUT > SNOOZE_TICKS)
                        ? ((ALARM_TIMEOUT > BLINK_TICKS) ? ALARM_TIMEOUT : BLINK_TICKS)
                        : ((SNOOZE_TICKS > BLINK_TICKS) ? SNOOZE_TICKS : BLINK_TICKS);
  localparam int TW   = $clog2(TMAX + 1);
  localparam int SW   = $clog2(MAX_SNOOZE + 1);

  state_t          cur, nxt;
  logic [CW-1:0]   cyc_cnt;
  logic [TW-1:0]   tick_cnt;
  logic [SW-1:0]   snooze_cnt;
  logic            pend_timer;

  logic            tick;
  logic            restart;
  logic            blink_restart;
  logic            snooze_inc, snooze_clr;
  logic            pend_set, pend_clr;
  logic            missed_set, missed_clr;
  logic            pend_any;
  state_t          exit_state;

  assign state      = cur;
  assign tick       = (cyc_cnt == CW'(TICK_CYCLES - 1));
  // A timer pulse arriving in the same cycle as the exit still counts as pending.
  assign pend_any   = pend_timer | timer_done;
  assign exit_state = pend_any ? S_BLINK : S_IDLE;
  assign restart    = (nxt != cur) || blink_restart;

  always_comb begin
    nxt           = cur;
    blink_restart = 1'b0;
    snooze_inc    = 1'b0;
    snooze_clr    = 1'b0;
    pend_set      = 1'b0;
    pend_clr      = 1'b0;
    missed_set    = 1'b0;
    missed_clr    = stop_btn;
    unique case (cur)
      S_IDLE: begin
        if (alarm_trig) begin
          nxt        = S_ALARM;
          snooze_clr = 1'b1;
          missed_clr = 1'b1;
          pend_set   = timer_done;
        end else if (timer_done) begin
          nxt = S_BLINK;
        end
      end
      S_ALARM: begin
        pend_set = timer_done;
        if (stop_btn) begin
          nxt      = exit_state;
          pend_clr = pend_any;
        end else if (snooze_btn && (snooze_cnt < SW'(MAX_SNOOZE))) begin
          nxt        = S_SNOOZE;
          snooze_inc = 1'b1;
        end else if (tick && (tick_cnt == TW'(ALARM_TIMEOUT - 1))) begin
          nxt        = exit_state;
          pend_clr   = pend_any;
          missed_set = 1'b1;
        end
      end
      S_SNOOZE: begin
        pend_set = timer_done;
        if (stop_btn) begin
          nxt      = exit_state;
          pend_clr = pend_any;
        end else if (tick && (tick_cnt == TW'(SNOOZE_TICKS - 1))) begin
          nxt = S_ALARM;
        end
      end
      S_BLINK: begin
        if (alarm_trig) begin
          nxt        = S_ALARM;
          snooze_clr = 1'b1;
          pend_set   = timer_done;
        end else if (stop_btn) begin
          nxt = S_IDLE;
        end else if (timer_done) begin
          blink_restart = 1'b1;
        end else if (tick && (tick_cnt == TW'(BLINK_TICKS - 1))) begin
          nxt = S_IDLE;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur          <= S_IDLE;
      cyc_cnt      <= '0;
      tick_cnt     <= '0;
      snooze_cnt   <= '0;
      pend_timer   <= 1'b0;
      missed       <= 1'b0;
      led_out      <= 1'b0;
      breath_en    <= 1'b0;
      breath_rst_n <= 1'b1;
    end else begin
      cur <= nxt;

      if (restart || (nxt == S_IDLE)) begin
        cyc_cnt  <= '0;
        tick_cnt <= '0;
      end else if (tick) begin
        cyc_cnt  <= '0;
        tick_cnt <= tick_cnt + TW'(1);
      end else begin
        cyc_cnt <= cyc_cnt + CW'(1);
      end

      if (snooze_clr)      snooze_cnt <= '0;
      else if (snooze_inc) snooze_cnt <= snooze_cnt + SW'(1);

      if (pend_clr)      pend_timer <= 1'b0;
      else if (pend_set) pend_timer <= 1'b1;

      if (missed_clr)      missed <= 1'b0;
      else if (missed_set) missed <= 1'b1;

      // Outputs follow the state being entered so they line up with the new state.
      breath_en    <= (nxt == S_ALARM);
      breath_rst_n <= !((nxt == S_ALARM) && (cur != S_ALARM));
      unique case (nxt)
        S_ALARM: led_out <= breath_pwm;
        S_BLINK: led_out <= restart ? 1'b1 : (tick ? ~led_out : led_out);
        default: led_out <= 1'b0;
      endcase
    end
  end

endmodule
